// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared encodings and constants for the MIPS pipeline control slice.
package mips_pipe_pkg;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LDSTALL   = 2'd1,
        STEP_WAIT = 2'd2,
        STEP_GO   = 2'd3
    } stateT;
    localparam int REG_W = 5;
    localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: enabled up-counter that sticks at all-ones, async active-low clear.
module hazard_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) count <= '0;
        else if (en && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch/jump flush and single-step sequencing for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] Rs_D,
    input  logic [REG_W-1:0] Rt_D,
    input  logic             RtUsed_D,
    input  logic             Jump_D,
    input  logic             MemRead_E,
    input  logic [REG_W-1:0] RegDst_E,
    input  logic             BranchTaken_M,
    input  logic             StepMode,
    input  logic             Step,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             PipeEn,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);
    localparam bit MULTI = STALL_CYCLES > 1;
    stateT state;
    logic [3:0] rem;
    logic stepQ, hazard, stall, run;
    assign hazard = MemRead_E && RegDst_E != '0 &&
                    (RegDst_E == Rs_D || (RtUsed_D && RegDst_E == Rt_D));
    // A pending rem in STEP_GO means the previous step left stall cycles unconsumed.
    assign stall = !BranchTaken_M && (hazard || state == LDSTALL || (state == STEP_GO && rem != '0));
    assign run = Reset && state != STEP_WAIT;
    assign PipeEn = run;
    assign PCWrite = run && !stall;
    assign IFID_Write = run && !stall;
    assign IDEX_Bubble = run && stall;
    assign IFID_Flush = run && (BranchTaken_M || (Jump_D && !stall));
    assign IDEX_Flush = run && BranchTaken_M;
    assign EXMEM_Flush = run && BranchTaken_M;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            rem <= '0;
            stepQ <= 1'b0;
        end else begin
            stepQ <= Step;
            case (state)
                RUN: begin
                    if (BranchTaken_M) rem <= '0;
                    else if (hazard && MULTI) rem <= REM_INIT;
                    state <= StepMode ? STEP_WAIT :
                             (!BranchTaken_M && hazard && MULTI) ? LDSTALL : RUN;
                end
                LDSTALL: begin
                    if (BranchTaken_M) begin
                        rem <= '0;
                        state <= RUN;
                    end else begin
                        rem <= rem - 1'b1;
                        if (rem == 4'd1) state <= RUN;
                    end
                end
                STEP_WAIT: begin
                    if (!StepMode) state <= (rem != '0) ? LDSTALL : RUN;
                    else if (Step && !stepQ) state <= STEP_GO;
                end
                STEP_GO: begin
                    if (BranchTaken_M) rem <= '0;
                    else if (rem != '0) rem <= rem - 1'b1;
                    else if (hazard && MULTI) rem <= REM_INIT;
                    state <= STEP_WAIT;
                end
            endcase
        end
    end
    hazard_sat_counter #(.W(CNT_W)) stallCnt (
        .Clk(Clk), .Reset(Reset), .en(IDEX_Bubble), .count(StallCount)
    );
    hazard_sat_counter #(.W(CNT_W)) flushCnt (
        .Clk(Clk), .Reset(Reset), .en(IDEX_Flush), .count(FlushCount)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall, flush, jump and single-step behaviour.
module tb_pipeline_hazard_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic [4:0] Rs_D = '0, Rt_D = '0, RegDst_E = '0;
    logic RtUsed_D = 0, Jump_D = 0, MemRead_E = 0, BranchTaken_M = 0, StepMode = 0, Step = 0;
    logic pcWr1, ifidWr1, bub1, ifidFl1, idexFl1, exmemFl1, pipeEn1;
    logic pcWr3, ifidWr3, bub3, ifidFl3, idexFl3, exmemFl3, pipeEn3;
    logic [15:0] stallCnt1, flushCnt1, stallCnt3, flushCnt3;
    int checks = 0;
    int errors = 0;
    int enCycles, pcAdv;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .Clk(Clk), .Reset(Reset), .Rs_D(Rs_D), .Rt_D(Rt_D), .RtUsed_D(RtUsed_D),
        .Jump_D(Jump_D), .MemRead_E(MemRead_E), .RegDst_E(RegDst_E),
        .BranchTaken_M(BranchTaken_M), .StepMode(StepMode), .Step(Step),
        .PCWrite(pcWr1), .IFID_Write(ifidWr1), .IDEX_Bubble(bub1), .IFID_Flush(ifidFl1),
        .IDEX_Flush(idexFl1), .EXMEM_Flush(exmemFl1), .PipeEn(pipeEn1),
        .StallCount(stallCnt1), .FlushCount(flushCnt1)
    );

    pipeline_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .Clk(Clk), .Reset(Reset), .Rs_D(Rs_D), .Rt_D(Rt_D), .RtUsed_D(RtUsed_D),
        .Jump_D(Jump_D), .MemRead_E(MemRead_E), .RegDst_E(RegDst_E),
        .BranchTaken_M(BranchTaken_M), .StepMode(StepMode), .Step(Step),
        .PCWrite(pcWr3), .IFID_Write(ifidWr3), .IDEX_Bubble(bub3), .IFID_Flush(ifidFl3),
        .IDEX_Flush(idexFl3), .EXMEM_Flush(exmemFl3), .PipeEn(pipeEn3),
        .StallCount(stallCnt3), .FlushCount(flushCnt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic clearInputs;
        Rs_D = '0; Rt_D = '0; RegDst_E = '0; RtUsed_D = 0;
        Jump_D = 0; MemRead_E = 0; BranchTaken_M = 0;
    endtask

    initial begin
        #12;
        check("rst_pcwrite", 32'(pcWr1), 0);
        check("rst_pipeen", 32'(pipeEn1), 0);
        check("rst_flush", 32'({ifidFl1, idexFl1, exmemFl1, bub1}), 0);
        check("rst_stallcnt", 32'(stallCnt1), 0);
        @(negedge Clk);
        Reset = 1'b1;
        tick;
        check("run_pipeen", 32'(pipeEn1), 1);

        // T1/T2: lw $2 in EX, add reading $2 in ID for one cycle
        MemRead_E = 1; RegDst_E = 5'd2; Rs_D = 5'd2;
        #1;
        check("t1_pcwrite", 32'(pcWr1), 0);
        check("t1_ifidwrite", 32'(ifidWr1), 0);
        check("t1_bubble", 32'(bub1), 1);
        check("t2_bubble_c1", 32'(bub3), 1);
        tick;
        clearInputs;
        #1;
        check("t1_pcwrite_after", 32'(pcWr1), 1);
        check("t1_stallcnt", 32'(stallCnt1), 1);
        check("t2_bubble_c2", 32'(bub3), 1);
        tick;
        #1;
        check("t2_bubble_c3", 32'(bub3), 1);
        check("t2_pcwrite_c3", 32'(pcWr3), 0);
        tick;
        #1;
        check("t2_bubble_done", 32'(bub3), 0);
        check("t2_pcwrite_done", 32'(pcWr3), 1);
        check("t2_stallcnt", 32'(stallCnt3), 3);

        // T1b: rt dependency only counts when rt is read
        MemRead_E = 1; RegDst_E = 5'd7; Rs_D = 5'd1; Rt_D = 5'd7; RtUsed_D = 0;
        #1;
        check("rt_unused_bubble", 32'(bub1), 0);
        RtUsed_D = 1;
        #1;
        check("rt_used_bubble", 32'(bub1), 1);
        tick;
        clearInputs;
        tick;
        tick;
        tick;

        // T3: load to $0 never stalls
        MemRead_E = 1; RegDst_E = 5'd0; Rs_D = 5'd0;
        #1;
        check("t3_bubble", 32'(bub1), 0);
        check("t3_pcwrite", 32'(pcWr1), 1);
        tick;
        clearInputs;

        // T4: taken branch overrides a simultaneous hazard
        MemRead_E = 1; RegDst_E = 5'd2; Rs_D = 5'd2; BranchTaken_M = 1;
        #1;
        check("t4_flushes", 32'({ifidFl1, idexFl1, exmemFl1}), 32'b111);
        check("t4_bubble", 32'(bub1), 0);
        check("t4_pcwrite", 32'(pcWr1), 1);
        check("t4_bubble3", 32'(bub3), 0);
        tick;
        clearInputs;
        #1;
        check("t4_flushcnt", 32'(flushCnt1), 1);
        check("t4_flushcnt3", 32'(flushCnt3), 1);
        check("t4_state_run3", 32'(bub3), 0);
        check("t4_flush_clear", 32'({ifidFl1, idexFl1, exmemFl1}), 0);

        // T5: jump without a hazard
        Jump_D = 1;
        #1;
        check("t5_ifidflush", 32'(ifidFl1), 1);
        check("t5_pcwrite", 32'(pcWr1), 1);
        check("t5_idexflush", 32'(idexFl1), 0);
        tick;
        Jump_D = 0;
        #1;
        check("t5_ifidflush_once", 32'(ifidFl1), 0);

        // T5b: jump with hazard: stall wins
        Jump_D = 1; MemRead_E = 1; RegDst_E = 5'd4; Rs_D = 5'd4;
        #1;
        check("jump_hazard_flush", 32'(ifidFl1), 0);
        tick;
        clearInputs;
        tick;
        tick;
        tick;

        // T6: single-step, three 2-cycle Step pulses
        StepMode = 1;
        tick;
        enCycles = 0;
        pcAdv = 0;
        for (int i = 0; i < 20; i++) begin
            Step = (i == 2 || i == 3 || i == 8 || i == 9 || i == 14 || i == 15);
            #1;
            if (pipeEn1) enCycles++;
            if (pcWr1) pcAdv += 4;
            tick;
        end
        check("t6_pipeen_cycles", 32'(enCycles), 3);
        check("t6_pc_advance", 32'(pcAdv), 12);
        check("t6_wait_pipeen", 32'(pipeEn1), 0);

        // T6 continued: reset while waiting for a step
        Reset = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({pcWr1, ifidWr1, pipeEn1, bub1, ifidFl1}), 0);
        check("t6_rst_stallcnt", 32'(stallCnt1), 0);
        Reset = 1'b1;
        #1;
        check("t6_release_run", 32'(pipeEn1), 1);
        check("t6_release_pcwrite", 32'(pcWr1), 1);
        StepMode = 0;
        tick;
        #1;
        check("t6_run_after", 32'(pipeEn1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
